// File: rtl/game_tile_probe_if.sv
// -----------------------------------------------------------------------------
// vga_if : raster timing bus shared by the map and overlay stages.
//   hcount/vcount : current pixel coordinates
//   hblnk/vblnk   : horizontal / vertical blanking flags
//   rgb           : pixel colour (unused by the tile probe)
// Modports: master drives the bus, slave and in both observe it.
// -----------------------------------------------------------------------------
interface vga_if;
   logic [10:0] hcount;
   logic [10:0] vcount;
   logic        hblnk;
   logic        vblnk;
   logic [11:0] rgb;

   modport master (output hcount, vcount, hblnk, vblnk, rgb);
   modport slave  (input  hcount, vcount, hblnk, vblnk, rgb);
   modport in     (input  hcount, vcount, hblnk, vblnk, rgb);
endinterface

// File: rtl/game_tile_probe.sv
// -----------------------------------------------------------------------------
// game_tile_probe : samples the map tile code under the player's probe point
// once per frame, debounces it across frames and presents a frame-stable
// tile code to the dialog overlay stage.
//   clk          : pixel clock
//   rst          : asynchronous, active-low reset
//   in           : raster timing bus (hcount, vcount, hblnk, vblnk)
//   map_code     : tile code of the pixel addressed by in.hcount/in.vcount
//   player_x/y   : player sprite top-left corner, screen pixels
//   current_pix  : committed tile code (0 = no tile / probe off-screen)
//   pix_valid    : set by the first commit after reset
//   pix_changed  : one-cycle pulse when current_pix takes a new value
// -----------------------------------------------------------------------------
module game_tile_probe #(
   parameter int OFFSET_X      = 16,
   parameter int OFFSET_Y      = 30,
   parameter int STABLE_FRAMES = 2
) (
   input  logic        clk,
   input  logic        rst,
   vga_if.in           in,
   input  logic [3:0]  map_code,
   input  logic [10:0] player_x,
   input  logic [10:0] player_y,
   output logic [3:0]  current_pix,
   output logic        pix_valid,
   output logic        pix_changed
);

   localparam logic [3:0] STABLE_N = 4'(STABLE_FRAMES);

   typedef enum logic [1:0] {ALIGN, SCAN, COMMIT} state_t;

   state_t      state, state_nxt;
   logic        vblnk_q;
   logic        fe;
   logic [11:0] px, py;
   logic        hit;
   logic [3:0]  sample;
   logic [3:0]  last_cand;
   logic [3:0]  stable_cnt;
   logic [3:0]  cand;
   logic [3:0]  cnt_inc, cnt_nxt;
   logic        probe_hit;
   logic        commit;
   logic        unused_rgb;

   assign unused_rgb = ^in.rgb;

   // Frame end: first cycle of vertical blanking.
   assign fe = in.vblnk & ~vblnk_q;

   // Bit 11 of either sum means the probe is off-screen and can never hit.
   assign probe_hit = (state == SCAN) && !hit &&
                      (in.hcount == px[10:0]) && (in.vcount == py[10:0]) &&
                      !in.hblnk && !in.vblnk && !px[11] && !py[11];

   // hit/sample are frozen during COMMIT, so the candidate can be formed here.
   assign cand    = hit ? sample : 4'h0;
   assign cnt_inc = (stable_cnt == 4'hF) ? 4'hF : stable_cnt + 4'd1;
   assign cnt_nxt = (cand == last_cand) ? cnt_inc : 4'd1;
   assign commit  = (state == COMMIT) && (cnt_nxt >= STABLE_N);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ALIGN;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ALIGN:   if (fe) state_nxt = SCAN;
         SCAN:    if (fe) state_nxt = COMMIT;
         COMMIT:  state_nxt = SCAN;
         default: state_nxt = ALIGN;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vblnk_q     <= 1'b0;
         px          <= '0;
         py          <= '0;
         hit         <= 1'b0;
         sample      <= '0;
         last_cand   <= '0;
         stable_cnt  <= '0;
         current_pix <= '0;
         pix_valid   <= 1'b0;
         pix_changed <= 1'b0;
      end else begin
         vblnk_q     <= in.vblnk;
         pix_changed <= 1'b0;

         // Probe position is frozen for the whole following frame.
         if (fe) begin
            px <= {1'b0, player_x} + 12'(OFFSET_X);
            py <= {1'b0, player_y} + 12'(OFFSET_Y);
         end

         // Outside SCAN hit is held clear, so every SCAN frame starts empty.
         if (state != SCAN) begin
            hit <= 1'b0;
         end else if (probe_hit) begin
            hit    <= 1'b1;
            sample <= map_code;
         end

         if (state == COMMIT) begin
            stable_cnt <= cnt_nxt;
            if (cand != last_cand) last_cand <= cand;
            if (commit) begin
               current_pix <= cand;
               pix_valid   <= 1'b1;
               pix_changed <= (cand != current_pix) || !pix_valid;
            end
         end
      end
   end

endmodule

// File: doc/game_tile_probe.md
# game_tile_probe

Upstream stage of the dialog overlay. Samples the 4-bit map tile code under the player's probe point once per frame from the map-code stream, debounces it across frames, and presents a stable `current_pix` tile code (plus a change strobe) that the dialog/overlay stage uses to select its text state. The overlay stage sees only frame-stable, debounced tile codes, never mid-frame glitches.

## Interface
- `OFFSET_X`, default 16: horizontal offset from `player_x` to the probe point.
- `OFFSET_Y`, default 30: vertical offset from `player_y` to the probe point (feet of sprite).
- `STABLE_FRAMES`, default 2: consecutive identical frame samples required before commit; legal range 1..15.
- `clk` in 1: pixel clock.
- `rst` in 1: asynchronous, active-low reset.
- `in` vga_if.in: timing bus. Uses `hcount`, `vcount`, `hblnk`, `vblnk`; `rgb` is ignored.
- `map_code` in 4: tile code of the pixel addressed by `in.hcount`/`in.vcount`, cycle-aligned with `in`.
- `player_x` in 11: player sprite left edge, screen pixels.
- `player_y` in 11: player sprite top edge, screen pixels.
- `current_pix` out 4: committed tile code. 0 means no tile or probe off-screen.
- `pix_valid` out 1: high once the first commit after reset has occurred.
- `pix_changed` out 1: one-cycle pulse when `current_pix` takes a new value.

## Operation
- Frame end is the cycle where `in.vblnk` is 1 and the registered previous `vblnk` is 0 (rising edge, `fe`).

**State machine**
- **ALIGN** (reset state): wait for `fe`, then go to SCAN.
- **SCAN**: one frame of sampling; on `fe` go to COMMIT.
- **COMMIT**: one cycle; always returns to SCAN.
- A new `fe` cannot occur during COMMIT, because vblank lasts many cycles.

**Probe position**
- At each `fe`, latch `px = player_x + OFFSET_X` and `py = player_y + OFFSET_Y`.
- Both sums are 12 bits wide. Bit 11 set means off-screen, which forces "no hit".
- Latched values are used for the whole following frame.
- Changes to `player_x`/`player_y` mid-frame have no effect.

**SCAN**
- Hit condition: `in.hcount == px[10:0]`, `in.vcount == py[10:0]`, `!in.hblnk`, `!in.vblnk`, and `px[11] == py[11] == 0`.
- On a hit cycle, register `sample <= map_code` and set `hit <= 1`.
- Only the first hit in a frame is captured.
- `hit` clears on entry to SCAN.

**Candidate selection (on `fe`)**
- `cand = hit ? sample : 4'h0`.

**COMMIT**
- If `cand == last_cand`, then `stable_cnt <= sat(stable_cnt + 1, 15)`.
- Otherwise `last_cand <= cand` and `stable_cnt <= 1`.
- Commit condition: the updated `stable_cnt >= STABLE_FRAMES`.
- On commit, `current_pix <= cand` and `pix_valid <= 1`.
- `pix_changed` pulses for one cycle, only when `cand != current_pix`, or on the first commit after reset.
- With `STABLE_FRAMES = 1`, every frame commits.

**Reset**
- All outputs and internal registers go to 0. `last_cand` resets to 0 and `stable_cnt` to 0. State resets to ALIGN.
- Reset mid-frame discards the partial sample. The first sample after reset is the first full frame following ALIGN.

## Timing
- Registered outputs only; no combinational path from inputs to outputs.
- `current_pix`, `pix_valid` and `pix_changed` update on the clock edge ending the COMMIT cycle, i.e. 2 cycles after the `fe` cycle.
- Commit latency: a tile change present from frame N is committed at the end of frame N + STABLE_FRAMES − 1.
- `pix_changed` is high for exactly 1 cycle per commit that changes the value, and is never high outside the cycle after COMMIT.
- `current_pix` holds between commits.
- Alternating candidates (A, B, A, B, …) never commit while `STABLE_FRAMES >= 2`.

## Test plan
- **Reset:** hold `rst = 0` mid-frame, release.
  - All outputs stay 0 through the first partial frame plus one full frame.
  - No `pix_changed` pulse before the first commit.
- **Steady tile:**
  - Setup: `player = (100, 200)`, `map_code = 4'h3` at (116, 230) and 0 elsewhere, `STABLE_FRAMES = 2`.
  - After the 2nd full frame: `current_pix = 3`, `pix_valid = 1`, one `pix_changed` pulse 2 cycles after `fe`.
  - Subsequent frames: no further pulses.
- **Debounce:**
  - Stimulus: tile 2 on frame 1, 4 on frame 2, 2 on frame 3, 2 on frame 4.
  - `current_pix` commits 2 only at the end of frame 4.
  - Exactly one pulse.
- **Mid-frame move:** change `player_x` after the probe line.
  - The probe uses the latched position; the new position takes effect from the next frame.
- **Off-screen:**
  - Stimulus: `player_y = 2040`, so `py` overflows and bit 11 is set.
  - Candidate is 0; after 2 frames `current_pix = 0` with a change pulse if the previous value was nonzero.
- **Reset mid-operation:** assert reset during COMMIT with `current_pix = 6`.
  - All outputs immediately 0; state returns to ALIGN.
